// File: rtl/hni_txchan_if.sv
// hni_txchan_if: source-side and link-side flit signals of one CHI TX channel.
//
// Handshake semantics:
//   Source side  - a flit transfers on a rising clk edge where src_valid and
//                  src_ready are both 1. src_ready depends only on channel
//                  state (never on src_valid), so src_valid may be held
//                  high while src_ready is 0.
//   Link side    - txflitv/txflit are registered; there is no backpressure.
//                  The link paces flits with L-credits: txlcrdv high for one
//                  cycle grants one credit. txflitpend is the early warning
//                  that a flit may appear on the next cycle.
//
// Modports:
//   master : environment view (drives source flits and credit grants)
//   slave  : channel view (hni_txchan)
interface hni_txchan_if #(
  parameter int FLIT_WIDTH = 392
);
  logic                  src_valid;
  logic [FLIT_WIDTH-1:0] src_flit;
  logic                  src_ready;
  logic                  txlcrdv;
  logic                  txflitv;
  logic [FLIT_WIDTH-1:0] txflit;
  logic                  txflitpend;

  modport master (
    output src_valid, src_flit, txlcrdv,
    input  src_ready, txflitv, txflit, txflitpend
  );

  modport slave (
    input  src_valid, src_flit, txlcrdv,
    output src_ready, txflitv, txflit, txflitpend
  );
endinterface

// File: rtl/hni_txchan.sv
// hni_txchan: CHI-E link-layer TX channel with staging FIFO, saturating
// L-credit accounting and the TX deactivation sequence (drain pending flits,
// then return every held credit as an all-zero LCrdReturn flit).
//
// Ports:
//   clk, rst        clock; asynchronous active-high reset
//   link_run        link is in RUN (from hni_link)
//   link_deact_req  level request to deactivate TX
//   bus             hni_txchan_if.slave: src_valid/src_flit/src_ready,
//                   txlcrdv, txflitv/txflit (registered), txflitpend (comb)
//   crd_cnt         credits currently held
//   crd_ret_done    one-cycle pulse in the first IDLE cycle after returning
//   crd_ovf_err     sticky: a credit arrived while already at MAX_CRD
//   state_o         debug view of the channel FSM (0 IDLE,1 RUN,2 DRAIN,3 RETURN)
module hni_txchan #(
  parameter  int FLIT_WIDTH = 392,
  parameter  int MAX_CRD    = 15,
  parameter  int FIFO_DEPTH = 4,
  localparam int CW         = $clog2(MAX_CRD + 1),
  localparam int AW         = $clog2(FIFO_DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          link_run,
  input  logic          link_deact_req,
  hni_txchan_if.slave   bus,
  output logic [CW-1:0] crd_cnt,
  output logic          crd_ret_done,
  output logic          crd_ovf_err,
  output logic [1:0]    state_o
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_DRAIN  = 2'd2,
    ST_RETURN = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [AW:0]           wr_ptr_q, rd_ptr_q;
  logic [FLIT_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [CW-1:0]         crd_cnt_q, crd_cnt_d;
  logic                  ovf_q, ovf_d;
  logic                  txflitv_q;
  logic [FLIT_WIDTH-1:0] txflit_q, txflit_d;
  logic                  done_q, done_d;

  logic fifo_empty, fifo_full, cr_av, push, pop, ret_send, send;

  // Extra pointer MSB distinguishes full from empty when the indices match.
  assign fifo_empty = (wr_ptr_q == rd_ptr_q);
  assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                      (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

  // A grant arriving this cycle may be spent in the same cycle.
  assign cr_av    = (crd_cnt_q != '0) | bus.txlcrdv;

  assign bus.src_ready = (state_q == ST_RUN) && !fifo_full;
  assign push     = bus.src_valid && bus.src_ready;
  assign pop      = ((state_q == ST_RUN) || (state_q == ST_DRAIN)) && !fifo_empty && cr_av;
  assign ret_send = (state_q == ST_RETURN) && cr_av;
  assign send     = pop | ret_send;

  assign txflit_d = pop ? mem_q[rd_ptr_q[AW-1:0]] : '0;

  assign bus.txflitpend = !fifo_empty || push || ret_send;
  assign bus.txflitv    = txflitv_q;
  assign bus.txflit     = txflit_q;
  assign crd_cnt        = crd_cnt_q;
  assign crd_ovf_err    = ovf_q;
  assign crd_ret_done   = done_q;
  assign state_o        = state_q;

  // Credit counter: a grant and a send in the same cycle cancel out, so
  // saturation only matters for an unmatched grant.
  always_comb begin
    crd_cnt_d = crd_cnt_q;
    ovf_d     = ovf_q;
    if (bus.txlcrdv && !send) begin
      if (crd_cnt_q == CW'(MAX_CRD)) ovf_d = 1'b1;
      else                          crd_cnt_d = crd_cnt_q + CW'(1);
    end else if (!bus.txlcrdv && send) begin
      crd_cnt_d = crd_cnt_q - CW'(1);
    end
  end

  always_comb begin
    state_d = state_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE:   if (link_run && !link_deact_req) state_d = ST_RUN;
      ST_RUN:    if (link_deact_req) state_d = ST_DRAIN;
      // Once deactivation starts it always runs to IDLE, even if the
      // request is withdrawn.
      ST_DRAIN:  if (fifo_empty) state_d = ST_RETURN;
      ST_RETURN: begin
        if ((crd_cnt_q == '0) && !bus.txlcrdv) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
        end
      end
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      crd_cnt_q <= '0;
      ovf_q     <= 1'b0;
      txflitv_q <= 1'b0;
      txflit_q  <= '0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      crd_cnt_q <= crd_cnt_d;
      ovf_q     <= ovf_d;
      txflitv_q <= send;
      txflit_q  <= txflit_d;
      done_q    <= done_d;
      if (push) wr_ptr_q <= wr_ptr_q + (AW+1)'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + (AW+1)'(1);
    end
  end

  // Storage needs no reset: entries are only read after being written.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q[AW-1:0]] <= bus.src_flit;
  end

endmodule
